// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, fetch defaults and the IF/ID
// pipeline record that decode also consumes.
package cpu_pkg;

   localparam int XLEN    = 32;
   localparam int INSTR_W = 32;

   localparam logic [XLEN-1:0]    DEF_RESET_PC = 32'h0000_0000;
   localparam logic [INSTR_W-1:0] DEF_NOP      = 32'h0000_0000;

   typedef struct packed {
      logic               valid;
      logic [INSTR_W-1:0] instr;
      logic [XLEN-1:0]    pc;
      logic [XLEN-1:0]    pc4;
      logic               err;
   } if_id_t;

   // Empty IF/ID slot; the bubble instruction is a parameter of the core.
   function automatic if_id_t if_id_empty(input logic [INSTR_W-1:0] nop);
      if_id_t r;
      r.valid = 1'b0;
      r.instr = nop;
      r.pc    = '0;
      r.pc4   = '0;
      r.err   = 1'b0;
      return r;
   endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Flush wins over hold; a flush turns the slot
// into a bubble but keeps the last pc/pc4.
module if_id_reg
   import cpu_pkg::*;
#(
   parameter logic [INSTR_W-1:0] NOP = DEF_NOP
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   i_flush,
   input  logic   i_hold,
   input  if_id_t i_d,
   output if_id_t o_q
);

   if_id_t r_q;

   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q <= if_id_empty(NOP);
      end else if (i_flush) begin
         r_q.valid <= 1'b0;
         r_q.instr <= NOP;
         r_q.err   <= 1'b0;
      end else if (!i_hold) begin
         r_q <= i_d;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: PC register, next-PC selection, misalignment check,
// retired-fetch counter and the IF/ID register feeding decode.
module ifu
   import cpu_pkg::*;
#(
   parameter logic [XLEN-1:0]    RESET_PC = DEF_RESET_PC,
   parameter logic [INSTR_W-1:0] NOP      = DEF_NOP
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               stall,
   input  logic               redirect,
   input  logic [XLEN-1:0]    redirect_pc,
   output logic [XLEN-1:0]    im_addr,
   input  logic [INSTR_W-1:0] im_data,
   output logic               id_valid,
   output logic [INSTR_W-1:0] id_instr,
   output logic [XLEN-1:0]    id_pc,
   output logic [XLEN-1:0]    id_pc4,
   output logic               id_err,
   output logic [XLEN-1:0]    fetch_cnt
);

   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_fetch_cnt;
   logic [XLEN-1:0] w_pc4;
   logic [XLEN-1:0] w_pc_next;
   logic            w_misaligned;
   logic            w_advance;
   if_id_t          w_fetch;
   if_id_t          w_id;

   assign w_pc4        = r_pc + 32'd4;
   assign w_misaligned = |r_pc[1:0];
   assign w_advance    = !redirect && !stall;

   always_comb begin
      w_pc_next = r_pc;
      if (redirect) begin
         w_pc_next = redirect_pc;
      end else if (!stall) begin
         w_pc_next = w_pc4;
      end
   end

   always_comb begin
      w_fetch.valid = 1'b1;
      w_fetch.instr = w_misaligned ? NOP : im_data;
      w_fetch.pc    = r_pc;
      w_fetch.pc4   = w_pc4;
      w_fetch.err   = w_misaligned;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc        <= RESET_PC;
         r_fetch_cnt <= '0;
      end else begin
         r_pc <= w_pc_next;
         if (w_advance) begin
            r_fetch_cnt <= r_fetch_cnt + 32'd1;
         end
      end
   end

   if_id_reg #(
      .NOP (NOP)
   ) u_if_id (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_flush (redirect),
      .i_hold  (stall),
      .i_d     (w_fetch),
      .o_q     (w_id)
   );

   assign im_addr   = r_pc;
   assign id_valid  = w_id.valid;
   assign id_instr  = w_id.instr;
   assign id_pc     = w_id.pc;
   assign id_pc4    = w_id.pc4;
   assign id_err    = w_id.err;
   assign fetch_cnt = r_fetch_cnt;

endmodule

// File: doc/ifu.md
# ifu

Instruction fetch unit for the MIPS core. It holds the program counter and drives the address of the combinational-read instruction memory. Each cycle it captures the returned word, with its PC and PC+4, into the IF/ID pipeline register consumed by decode. It also supports stall, redirect (branch/jump/jr) with flush, misaligned-fetch flagging and a retired-fetch counter.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP, 32'h0000_0000, instruction word inserted on flush or fault.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low. One clock; async active-low reset.
- stall  in  1  hold PC and IF/ID contents (hazard from decode).
- redirect  in  1  load redirect_pc into PC and flush IF/ID.
- redirect_pc  in  32  target address from branch/jump resolution.
- im_addr  out  32  byte address to instruction memory; equals PC.
- im_data  in  32  instruction word returned combinationally for im_addr.
- id_valid  out  1  IF/ID holds a real fetched instruction.
- id_instr  out  32  fetched instruction (NOP when invalid or faulted).
- id_pc  out  32  address the instruction was fetched from.
- id_pc4  out  32  id_pc + 4 (link value for jal/jalr).
- id_err  out  1  fetch address was not word-aligned.
- fetch_cnt  out  32  count of valid instructions delivered to IF/ID.

## Operation
- PC register; im_addr = PC, combinational, no added delay.
- Per rising edge, priority order:
  1. redirect=1: PC <= redirect_pc; id_valid <= 0, id_instr <= NOP, id_err <= 0; id_pc/id_pc4 hold. Overrides stall.
  2. stall=1: PC and all id_* hold; fetch_cnt holds.
  3. Otherwise: PC <= PC+4; id_pc <= PC; id_pc4 <= PC+4; id_valid <= 1; fetch_cnt <= fetch_cnt+1.
     - If PC[1:0]==0: id_instr <= im_data, id_err <= 0.
     - Else: id_instr <= NOP, id_err <= 1.
- Arithmetic: PC+4 is 32-bit modulo; 32'hFFFF_FFFC wraps to 32'h0000_0000 with no flag. fetch_cnt wraps modulo 2^32.
- Misaligned redirect_pc is loaded as-is. Sequential PCs stay misaligned (+4) until the next redirect, and each one is reported with id_err=1.
- No state machine beyond the PC and IF/ID registers. Only two modes: run and hold.

## Timing
- Reset (asynchronous assert, immediate): PC=RESET_PC, id_valid=0, id_instr=NOP, id_pc=0, id_pc4=0, id_err=0, fetch_cnt=0.
  - First edge after rst_n deasserts (no stall/redirect): id_instr=mem[RESET_PC], id_pc=RESET_PC.
- Fetch latency: one cycle from PC to id_*.
- Redirect asserted in cycle n: edge n sets PC=target and a bubble (id_valid=0); edge n+1 delivers the target instruction. Penalty is exactly one bubble.
- stall held for k cycles freezes id_* for k edges, with no instruction lost or duplicated.
- Reset asserted mid-operation clears all state immediately, regardless of stall/redirect.

## Structure
- Shared package cpu_pkg holds:
  - width constants: XLEN=32, INSTR_W=32.
  - default RESET_PC and NOP.
  - packed struct if_id_t {valid, instr, pc, pc4, err}, also used by decode.
- One sub-module, if_id_reg: the IF/ID register with flush (priority) and hold controls, async active-low reset to the if_id_t reset value.
- ifu itself contains the PC register, next-PC mux, misalignment check and fetch_cnt.
- Instruction memory instantiated beside ifu at top level: im_addr to memory address, memory data to im_data.

## Test plan
- Reset/sequential: memory words 0x20080001, 0x20090002, 0x01095020 at 0x0/0x4/0x8.
  - -> after 3 edges, id_* shows instr 0x01095020, pc 0x8, pc4 0xC; fetch_cnt=3.
- Stall: stall=1 for 2 cycles while id_pc=0x4.
  - -> id_pc stays 0x4 and im_addr stays 0x8 for both cycles; the next edge gives id_pc=0x8.
- Redirect+stall same cycle: redirect_pc=0x40, stall=1.
  - -> next edge PC=0x40 and id_valid=0; the following edge gives id_pc=0x40 and id_valid=1.
- Misaligned: redirect_pc=0x42.
  - -> one bubble, then id_err=1, id_instr=NOP, id_pc=0x42; next fetch id_pc=0x46 with id_err=1.
- Wrap: RESET_PC=32'hFFFF_FFFC.
  - -> first fetch id_pc4=0x0; im_addr becomes 0x0.
- Async reset mid-run: drop rst_n between edges.
  - -> outputs reach reset values without a clock edge; fetch_cnt=0.
